// File: rtl/mox_dwb_pkg.sv
// mox_dwb_pkg: shared encodings for the mox data-bus master and its lane steering.
// Holds access sizes, FSM states, big-endian byte-lane selects and the alignment check.
package mox_dwb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  // Lane bit 3 carries bits 31:24, so the lowest byte address maps to the MSB lane.
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mox_dwb_if.sv
// mox_dwb_if: Wishbone classic data-bus signal bundle (wb_D_*).
// The master modport drives the cycle; the slave modport returns data and ack.
interface mox_dwb_if;
  logic [31:0] wb_D_adr_o;
  logic [31:0] wb_D_dat_o;
  logic [3:0]  wb_D_sel_o;
  logic        wb_D_we_o;
  logic        wb_D_cyc_o;
  logic        wb_D_stb_o;
  logic [31:0] wb_D_dat_i;
  logic        wb_D_ack_i;

  modport master (
    output wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o,
    input  wb_D_dat_i, wb_D_ack_i
  );

  modport slave (
    input  wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o,
    output wb_D_dat_i, wb_D_ack_i
  );
endinterface

// File: rtl/mox_dwb_lane.sv
// mox_dwb_lane: combinational big-endian byte-lane steering for sub-word accesses.
// Produces lane select and replicated store data, and extracts load data by lane select.
module mox_dwb_lane
  import mox_dwb_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [3:0]  rd_sel,
  input  logic [31:0] rd_word,
  output logic [3:0]  sel,
  output logic [31:0] st_lanes,
  output logic [31:0] rd_data
);

  always_comb begin
    sel = '0;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    sel = SEL_B0;
          2'd1:    sel = SEL_B1;
          2'd2:    sel = SEL_B2;
          default: sel = SEL_B3;
        endcase
      end
      SZ_HALF: sel = addr_lo[1] ? SEL_H1 : SEL_H0;
      SZ_WORD: sel = SEL_W;
      default: sel = '0;
    endcase
  end

  // Replicating across all lanes lets the slave pick any lane without a shifter.
  always_comb begin
    st_lanes = st_data;
    case (size)
      SZ_BYTE: st_lanes = {4{st_data[7:0]}};
      SZ_HALF: st_lanes = {2{st_data[15:0]}};
      default: st_lanes = st_data;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_B0:  rd_data = {24'd0, rd_word[31:24]};
      SEL_B1:  rd_data = {24'd0, rd_word[23:16]};
      SEL_B2:  rd_data = {24'd0, rd_word[15:8]};
      SEL_B3:  rd_data = {24'd0, rd_word[7:0]};
      SEL_H0:  rd_data = {16'd0, rd_word[31:16]};
      SEL_H1:  rd_data = {16'd0, rd_word[15:0]};
      SEL_W:   rd_data = rd_word;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mox_dwb_master.sv
// mox_dwb_master: Wishbone classic data-bus master turning load/store requests into single cycles.
// Optional macro DWB_TIMEOUT_EN aborts a cycle after TIMEOUT_CYCLES without wb_D_ack_i.
module mox_dwb_master
  import mox_dwb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_reg_i,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic [3:0]  ld_reg_o,
  output logic        err_o,
  output logic        stall_o,
  mox_dwb_if.master   wb
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mox_dwb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q, state_d;
  size_e       req_size;
  logic        req_bad, accept, in_bus, ack;
  logic        start, finish, abort, timeout_hit;
  logic [31:0] adr_q, dat_q, ld_data_q;
  logic [3:0]  sel_q, reg_q, ld_reg_q;
  logic        we_q, ld_valid_q, err_q;
  logic [3:0]  lane_sel;
  logic [31:0] lane_st, lane_rd;

  assign req_size    = size_e'(req_size_i);
  assign req_bad     = is_misaligned(req_size, req_addr_i[1:0]);
  assign in_bus      = (state_q == BUS);
  assign ack         = wb.wb_D_ack_i;
  assign req_ready_o = ~in_bus & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  // Combinational on req_valid_i so the write stage holds its request through the accept cycle.
  assign stall_o     = in_bus | (accept & ~req_bad);

  mox_dwb_lane u_lane (
    .size     (req_size),
    .addr_lo  (req_addr_i[1:0]),
    .st_data  (req_data_i),
    .rd_sel   (sel_q),
    .rd_word  (wb.wb_D_dat_i),
    .sel      (lane_sel),
    .st_lanes (lane_st),
    .rd_data  (lane_rd)
  );

`ifdef DWB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (start) begin
      wait_cnt_q <= '0;
    end else if (in_bus && !ack) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack takes priority over timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !req_bad) begin
          state_d = BUS;
          start   = 1'b1;
        end
      end
      BUS: begin
        if (ack) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      reg_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      ld_reg_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      ld_valid_q <= 1'b0;
      err_q      <= (accept & req_bad) | abort;
      if (start) begin
        adr_q <= {req_addr_i[31:2], 2'b00};
        dat_q <= lane_st;
        sel_q <= lane_sel;
        we_q  <= req_we_i;
        reg_q <= req_reg_i;
      end
      if (finish && !we_q) begin
        ld_valid_q <= 1'b1;
        ld_data_q  <= lane_rd;
        ld_reg_q   <= reg_q;
      end
    end
  end

  // Cycle/strobe follow the state register directly, so reset drops them asynchronously.
  assign wb.wb_D_cyc_o = in_bus;
  assign wb.wb_D_stb_o = in_bus;
  assign wb.wb_D_we_o  = in_bus & we_q;
  assign wb.wb_D_adr_o = adr_q;
  assign wb.wb_D_dat_o = dat_q;
  assign wb.wb_D_sel_o = sel_q;

  assign ld_valid_o = ld_valid_q;
  assign ld_data_o  = ld_data_q;
  assign ld_reg_o   = ld_reg_q;
  assign err_o      = err_q;

endmodule
